// File: rtl/debug_pulse_meter.sv
// Gated per-channel edge/high-cycle meter over an N-cycle window; results appear N cycles after START.
// No backpressure: RESULT_VALID_O is a 1-cycle pulse, results hold until the next window or reset.
module debug_pulse_meter #(
  parameter int C_CH         = 4,
  parameter int C_CNT_WIDTH  = 32,
  parameter int C_GATE_WIDTH = 32
) (
  input  logic                        CLK_I,
  input  logic                        RST_I,
  input  logic [C_CH-1:0]             DEBUG_I,
  input  logic                        START_I,
  input  logic                        ABORT_I,
  input  logic                        CONTINUOUS_I,
  input  logic [C_GATE_WIDTH-1:0]     GATE_CYCLES_I,
  output logic                        BUSY_O,
  output logic                        RESULT_VALID_O,
  output logic [C_CH*C_CNT_WIDTH-1:0] EDGE_CNT_O,
  output logic [C_CH*C_CNT_WIDTH-1:0] HIGH_CNT_O,
  output logic [C_CH-1:0]             OVF_O,
  output logic [15:0]                 WINDOW_SEQ_O
);

  typedef enum logic {IDLE, RUN} state_t;
  typedef logic [C_CH-1:0][C_CNT_WIDTH-1:0] cnt_arr_t;

  state_t                   state_q, state_d;
  logic [C_GATE_WIDTH-1:0]  gate_q, gate_d;
  logic [C_CH-1:0]          prev_q, prev_d;
  cnt_arr_t                 acc_edge_q, acc_edge_d;
  cnt_arr_t                 acc_high_q, acc_high_d;
  logic [C_CH-1:0]          ovf_q, ovf_d;
  cnt_arr_t                 edge_out_q, edge_out_d;
  cnt_arr_t                 high_out_q, high_out_d;
  logic [C_CH-1:0]          ovf_out_q, ovf_out_d;
  logic [15:0]              seq_q, seq_d;
  logic                     busy_q, busy_d;
  logic                     valid_q, valid_d;

  logic [C_CH-1:0]          rise;
  cnt_arr_t                 edge_nxt, high_nxt;
  logic [C_CH-1:0]          ovf_nxt;
  logic                     last_sample;
  logic                     gate_ok;

  // Saturating next-sample values, including this cycle's increment.
  always_comb begin
    rise     = DEBUG_I & ~prev_q;
    edge_nxt = acc_edge_q;
    high_nxt = acc_high_q;
    ovf_nxt  = ovf_q;
    for (int i = 0; i < C_CH; i++) begin
      if (rise[i]) begin
        if (&acc_edge_q[i]) ovf_nxt[i] = 1'b1;
        else                edge_nxt[i] = acc_edge_q[i] + C_CNT_WIDTH'(1);
      end
      if (DEBUG_I[i]) begin
        if (&acc_high_q[i]) ovf_nxt[i] = 1'b1;
        else                high_nxt[i] = acc_high_q[i] + C_CNT_WIDTH'(1);
      end
    end
  end

  assign last_sample = (gate_q == C_GATE_WIDTH'(1));
  assign gate_ok     = (GATE_CYCLES_I != '0);

  always_comb begin
    state_d    = state_q;
    gate_d     = gate_q;
    prev_d     = DEBUG_I;
    acc_edge_d = acc_edge_q;
    acc_high_d = acc_high_q;
    ovf_d      = ovf_q;
    edge_out_d = edge_out_q;
    high_out_d = high_out_q;
    ovf_out_d  = ovf_out_q;
    seq_d      = seq_q;
    valid_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (START_I && !ABORT_I && gate_ok) begin
          state_d    = RUN;
          gate_d     = GATE_CYCLES_I;
          acc_edge_d = '0;
          acc_high_d = '0;
          ovf_d      = '0;
        end
      end
      RUN: begin
        if (ABORT_I) begin
          state_d = IDLE;
        end else if (last_sample) begin
          edge_out_d = edge_nxt;
          high_out_d = high_nxt;
          ovf_out_d  = ovf_nxt;
          valid_d    = 1'b1;
          seq_d      = seq_q + 16'd1;
          acc_edge_d = '0;
          acc_high_d = '0;
          ovf_d      = '0;
          // A zero length on reload cannot form a window, so stop instead.
          if (CONTINUOUS_I && gate_ok) gate_d = GATE_CYCLES_I;
          else                         state_d = IDLE;
        end else begin
          acc_edge_d = edge_nxt;
          acc_high_d = high_nxt;
          ovf_d      = ovf_nxt;
          gate_d     = gate_q - C_GATE_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q    <= IDLE;
      gate_q     <= '0;
      prev_q     <= '0;
      acc_edge_q <= '0;
      acc_high_q <= '0;
      ovf_q      <= '0;
      edge_out_q <= '0;
      high_out_q <= '0;
      ovf_out_q  <= '0;
      seq_q      <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_q     <= gate_d;
      prev_q     <= prev_d;
      acc_edge_q <= acc_edge_d;
      acc_high_q <= acc_high_d;
      ovf_q      <= ovf_d;
      edge_out_q <= edge_out_d;
      high_out_q <= high_out_d;
      ovf_out_q  <= ovf_out_d;
      seq_q      <= seq_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
    end
  end

  assign BUSY_O         = busy_q;
  assign RESULT_VALID_O = valid_q;
  assign EDGE_CNT_O     = edge_out_q;
  assign HIGH_CNT_O     = high_out_q;
  assign OVF_O          = ovf_out_q;
  assign WINDOW_SEQ_O   = seq_q;

endmodule
